// File: rtl/pll_lock_supervisor.sv
// PLL bring-up supervisor: times the rPLL RESET pulse, qualifies the asynchronous LOCK
// and holds the TMDS/video domain in reset until lock has been stable long enough.
module pll_lock_supervisor #(
    parameter int unsigned RESET_PULSE_CYCLES  = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65535,
    parameter int unsigned SYNC_STAGES         = 2,
    parameter int unsigned RETRY_W             = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pll_lock,
    input  logic               force_relock,
    output logic               pll_reset,
    output logic               sys_reset,
    output logic               ready,
    output logic [RETRY_W-1:0] retry_count
);

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_e;

    // The single shared timer must reach the largest terminal count of any state.
    localparam int unsigned T_MAX_A = (RESET_PULSE_CYCLES > LOCK_STABLE_CYCLES) ?
                                      RESET_PULSE_CYCLES : LOCK_STABLE_CYCLES;
    localparam int unsigned T_MAX   = (T_MAX_A > LOCK_TIMEOUT_CYCLES) ?
                                      T_MAX_A : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned TW      = $clog2(T_MAX + 1);

    localparam logic [TW-1:0] RST_LAST     = TW'(RESET_PULSE_CYCLES - 1);
    localparam logic [TW-1:0] STABLE_LAST  = TW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);

    state_e                   state_q, state_d;
    logic [TW-1:0]            timer_q, timer_d;
    logic [RETRY_W-1:0]       retry_q, retry_d;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     pll_reset_q;
    logic                     sys_reset_q;
    logic                     ready_q;
    logic                     lock_s;

    assign lock_s = sync_q[SYNC_STAGES-1];

    // NOTE: every variable gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 1'b1;
        retry_d = retry_q;

        if (force_relock) begin
            state_d = PLL_RST;
            timer_d = '0;
        end else begin
            unique case (state_q)
                PLL_RST: begin
                    if (timer_q == RST_LAST) begin
                        state_d = WAIT_LOCK;
                        timer_d = '0;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = STABLE;
                        timer_d = '0;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        state_d = PLL_RST;
                        timer_d = '0;
                        if (retry_q != '1) retry_d = retry_q + 1'b1;
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state_d = WAIT_LOCK;
                        timer_d = '0;
                    end else if (timer_q == STABLE_LAST) begin
                        state_d = RUN;
                        timer_d = '0;
                    end
                end
                RUN: begin
                    timer_d = timer_q;
                    if (!lock_s) begin
                        state_d = PLL_RST;
                        timer_d = '0;
                        if (retry_q != '1) retry_d = retry_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= PLL_RST;
            timer_q     <= '0;
            retry_q     <= '0;
            sync_q      <= '0;
            pll_reset_q <= 1'b1;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            sync_q      <= {sync_q[SYNC_STAGES-2:0], pll_lock};
            // Outputs decode the next state so they switch on the same edge as state_q.
            pll_reset_q <= (state_d == PLL_RST);
            sys_reset_q <= (state_d != RUN);
            ready_q     <= (state_d == RUN);
        end
    end

    assign pll_reset   = pll_reset_q;
    assign sys_reset   = sys_reset_q;
    assign ready       = ready_q;
    assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with short timing parameters; edges are counted
// from reset release and inputs change 1 time unit after a rising edge.
module tb_pll_lock_supervisor;

    localparam int unsigned RP = 4;
    localparam int unsigned LS = 8;
    localparam int unsigned LT = 32;
    localparam int unsigned SS = 2;
    localparam int unsigned RW = 2;

    logic          clk          = 1'b0;
    logic          clk_en       = 1'b1;
    logic          reset        = 1'b1;
    logic          pll_lock     = 1'b0;
    logic          force_relock = 1'b0;
    logic          pll_reset;
    logic          sys_reset;
    logic          ready;
    logic [RW-1:0] retry_count;
    logic [4:0]    obs;

    int n_checks = 0;
    int n_errors = 0;

    assign obs = {pll_reset, sys_reset, ready, retry_count};

    pll_lock_supervisor #(
        .RESET_PULSE_CYCLES (RP),
        .LOCK_STABLE_CYCLES (LS),
        .LOCK_TIMEOUT_CYCLES(LT),
        .SYNC_STAGES        (SS),
        .RETRY_W            (RW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pll_lock    (pll_lock),
        .force_relock(force_relock),
        .pll_reset   (pll_reset),
        .sys_reset   (sys_reset),
        .ready       (ready),
        .retry_count (retry_count)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds reset for two edges, then releases it 1 unit after an edge; next edge is edge 1.
    task automatic apply_reset();
        reset        = 1'b1;
        pll_lock     = 1'b0;
        force_relock = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(2);
        n_checks++;
        if (obs !== {1'b1, 1'b1, 1'b0, 2'd0}) begin
            n_errors++;
            $display("FAIL reset_state: {pll_reset,sys_reset,ready,retry}=%b expected 11000", obs);
        end
    endtask

    task automatic test_bring_up();
        apply_reset();
        for (int e = 1; e <= 3; e++) begin
            tick();
            n_checks++;
            if (obs !== {1'b1, 1'b1, 1'b0, 2'd0}) begin
                n_errors++;
                $display("FAIL bringup_pulse edge %0d: outputs=%b expected 11000", e, obs);
            end
        end
        tick();
        n_checks++;
        if (obs !== {1'b0, 1'b1, 1'b0, 2'd0}) begin
            n_errors++;
            $display("FAIL bringup_pulse_end edge 4: outputs=%b expected 01000", obs);
        end
        tick(10);
        pll_lock = 1'b1;
        tick(10);
        n_checks++;
        if (obs !== {1'b0, 1'b1, 1'b0, 2'd0}) begin
            n_errors++;
            $display("FAIL bringup_before_release edge 24: outputs=%b expected 01000", obs);
        end
        tick();
        n_checks++;
        if (obs !== {1'b0, 1'b0, 1'b1, 2'd0}) begin
            n_errors++;
            $display("FAIL bringup_release edge 25: outputs=%b expected 00100", obs);
        end
    endtask

    task automatic test_never_lock();
        logic [4:0] exp;
        int         k;
        apply_reset();
        for (int e = 1; e <= 150; e++) begin
            tick();
            k   = e / 36;
            exp = {((e % 36) <= 3), 1'b1, 1'b0, RW'((k > 3) ? 3 : k)};
            n_checks++;
            if (obs !== exp) begin
                n_errors++;
                $display("FAIL never_lock edge %0d: outputs=%b expected %b", e, obs, exp);
            end
        end
    endtask

    task automatic test_stable_glitch();
        apply_reset();
        tick(4);
        pll_lock = 1'b1;
        tick(5);
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        tick(5);
        n_checks++;
        if (obs !== {1'b0, 1'b1, 1'b0, 2'd0}) begin
            n_errors++;
            $display("FAIL glitch_no_early_release edge 15: outputs=%b expected 01000", obs);
        end
        tick(5);
        n_checks++;
        if (obs !== {1'b0, 1'b1, 1'b0, 2'd0}) begin
            n_errors++;
            $display("FAIL glitch_before_release edge 20: outputs=%b expected 01000", obs);
        end
        tick();
        n_checks++;
        if (obs !== {1'b0, 1'b0, 1'b1, 2'd0}) begin
            n_errors++;
            $display("FAIL glitch_release edge 21: outputs=%b expected 00100", obs);
        end
    endtask

    task automatic test_run_loss();
        apply_reset();
        tick(4);
        pll_lock = 1'b1;
        tick(11);
        n_checks++;
        if (obs !== {1'b0, 1'b0, 1'b1, 2'd0}) begin
            n_errors++;
            $display("FAIL loss_in_run edge 15: outputs=%b expected 00100", obs);
        end
        pll_lock = 1'b0;
        tick(2);
        n_checks++;
        if (obs !== {1'b0, 1'b0, 1'b1, 2'd0}) begin
            n_errors++;
            $display("FAIL loss_not_yet edge 17: outputs=%b expected 00100", obs);
        end
        tick();
        n_checks++;
        if (obs !== {1'b1, 1'b1, 1'b0, 2'd1}) begin
            n_errors++;
            $display("FAIL loss_detect edge 18: outputs=%b expected 11001", obs);
        end
        tick(3);
        n_checks++;
        if (obs !== {1'b1, 1'b1, 1'b0, 2'd1}) begin
            n_errors++;
            $display("FAIL loss_pulse edge 21: outputs=%b expected 11001", obs);
        end
        tick();
        n_checks++;
        if (obs !== {1'b0, 1'b1, 1'b0, 2'd1}) begin
            n_errors++;
            $display("FAIL loss_pulse_end edge 22: outputs=%b expected 01001", obs);
        end
    endtask

    task automatic test_force_relock();
        apply_reset();
        tick(4);
        pll_lock = 1'b1;
        tick(11);
        pll_lock = 1'b0;
        tick(2);
        force_relock = 1'b1;
        tick();
        force_relock = 1'b0;
        n_checks++;
        if (obs !== {1'b1, 1'b1, 1'b0, 2'd0}) begin
            n_errors++;
            $display("FAIL force_on_loss edge 18: outputs=%b expected 11000", obs);
        end
        tick(4);
        n_checks++;
        if (obs !== {1'b0, 1'b1, 1'b0, 2'd0}) begin
            n_errors++;
            $display("FAIL force_on_loss_pulse_end edge 22: outputs=%b expected 01000", obs);
        end
        tick(31);
        n_checks++;
        if (obs !== {1'b0, 1'b1, 1'b0, 2'd0}) begin
            n_errors++;
            $display("FAIL force_wait_t31 edge 53: outputs=%b expected 01000", obs);
        end
        force_relock = 1'b1;
        tick();
        force_relock = 1'b0;
        n_checks++;
        if (obs !== {1'b1, 1'b1, 1'b0, 2'd0}) begin
            n_errors++;
            $display("FAIL force_on_timeout edge 54: outputs=%b expected 11000", obs);
        end
        tick(4);
        n_checks++;
        if (obs !== {1'b0, 1'b1, 1'b0, 2'd0}) begin
            n_errors++;
            $display("FAIL force_on_timeout_pulse_end edge 58: outputs=%b expected 01000", obs);
        end
        force_relock = 1'b1;
        tick();
        force_relock = 1'b0;
        tick(2);
        force_relock = 1'b1;
        tick();
        force_relock = 1'b0;
        tick(3);
        n_checks++;
        if (obs !== {1'b1, 1'b1, 1'b0, 2'd0}) begin
            n_errors++;
            $display("FAIL force_restart_pulse edge 65: outputs=%b expected 11000", obs);
        end
        tick();
        n_checks++;
        if (obs !== {1'b0, 1'b1, 1'b0, 2'd0}) begin
            n_errors++;
            $display("FAIL force_restart_pulse_end edge 66: outputs=%b expected 01000", obs);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        tick(45);
        n_checks++;
        if (obs !== {1'b0, 1'b1, 1'b0, 2'd1}) begin
            n_errors++;
            $display("FAIL async_pre_wait edge 45: outputs=%b expected 01001", obs);
        end
        clk_en = 1'b0;
        #7;
        reset = 1'b1;
        #1;
        n_checks++;
        if (obs !== {1'b1, 1'b1, 1'b0, 2'd0}) begin
            n_errors++;
            $display("FAIL async_reset_no_clock: outputs=%b expected 11000", obs);
        end
    endtask

    initial begin
        test_reset();
        test_bring_up();
        test_never_lock();
        test_stable_glitch();
        test_run_loss();
        test_force_relock();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
